// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_pkg
// Description : Shared encodings for the sensor conditioner and the FSM that
//               consumes its outputs. Optional macro: MEDIAN3_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    typedef enum logic [1:0] {
        PH_NIGHT = 2'b00,
        PH_DAWN  = 2'b01,
        PH_DAY   = 2'b10,
        PH_DUSK  = 2'b11
    } phase_t;

    localparam logic CH_MOIST = 1'b0;
    localparam logic CH_LIGHT = 1'b1;

`ifdef MEDIAN3_EN
    function automatic logic [7:0] median3(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c > hi) ? hi : ((c < lo) ? lo : c);
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/chan_avg.sv
`default_nettype none
// ============================================================================
// Module      : chan_avg
// Description : Per-channel box-car averager with optional 3-tap median
//               prefilter (MEDIAN3_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module chan_avg
    import sensor_pkg::*;
#(
    parameter int         AVG_LOG2  = 3,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sample_en,
    input  logic [7:0] i_sample,
    output logic [7:0] o_avg,
    output logic       o_valid
);

    localparam int c_ACC_W = 8 + AVG_LOG2;

    logic [c_ACC_W-1:0]  r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [7:0]          w_filt;
    logic [c_ACC_W-1:0]  w_sum;
    logic                w_last;

`ifdef MEDIAN3_EN
    logic [7:0] r_h1;
    logic [7:0] r_h2;
    logic       r_primed;

    // First sample seeds both taps so the filter has no startup bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1     <= 8'd0;
            r_h2     <= 8'd0;
            r_primed <= 1'b0;
        end else if (i_sample_en) begin
            r_h1     <= i_sample;
            r_h2     <= r_primed ? r_h1 : i_sample;
            r_primed <= 1'b1;
        end
    end

    assign w_filt = r_primed ? median3(i_sample, r_h1, r_h2) : i_sample;
`else
    assign w_filt = i_sample;
`endif

    assign w_sum  = r_acc + {{AVG_LOG2{1'b0}}, w_filt};
    assign w_last = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            o_avg   <= RESET_VAL;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_sample_en) begin
                r_cnt <= r_cnt + AVG_LOG2'(1);
                if (w_last) begin
                    o_avg   <= w_sum[c_ACC_W-1:AVG_LOG2];
                    o_valid <= 1'b1;
                    r_acc   <= '0;
                end else begin
                    r_acc   <= w_sum;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sensor_conditioner
// Description : ADC handshake, per-channel averaging and daylight phase FSM
//               with hysteresis and persistence. Optional macro: MEDIAN3_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int         AVG_LOG2    = 3,
    parameter logic [7:0] LIGHT_HI    = 8'd120,
    parameter logic [7:0] LIGHT_LO    = 8'd60,
    parameter int         PERSIST_SEC = 600,
    parameter int         DAWN_SEC    = 1800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       adc_valid,
    input  logic       adc_chan,
    input  logic [7:0] adc_data,
    output logic       adc_ready,
    output logic [7:0] m_sense,
    output logic [7:0] l_sense,
    output logic [1:0] l_thresh,
    output logic       m_valid,
    output logic       l_valid
);

    localparam logic [11:0] c_PERSIST = 12'(PERSIST_SEC);
    localparam logic [11:0] c_DWELL   = 12'(DAWN_SEC);

    logic w_xfer;
    logic w_m_en;
    logic w_l_en;

    // Either channel's commit cycle stalls the ADC for exactly one cycle.
    assign adc_ready = rst_n & ~(m_valid | l_valid);
    assign w_xfer    = adc_valid & adc_ready;
    assign w_m_en    = w_xfer & (adc_chan == CH_MOIST);
    assign w_l_en    = w_xfer & (adc_chan == CH_LIGHT);

    chan_avg #(
        .AVG_LOG2  (AVG_LOG2),
        .RESET_VAL (8'hFF)
    ) u_moist (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sample_en (w_m_en),
        .i_sample    (adc_data),
        .o_avg       (m_sense),
        .o_valid     (m_valid)
    );

    chan_avg #(
        .AVG_LOG2  (AVG_LOG2),
        .RESET_VAL (8'h00)
    ) u_light (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sample_en (w_l_en),
        .i_sample    (adc_data),
        .o_avg       (l_sense),
        .o_valid     (l_valid)
    );

    phase_t      r_phase;
    phase_t      w_phase_nxt;
    logic [11:0] r_cnt;
    logic [11:0] w_cnt_nxt;
    logic [11:0] w_cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_NIGHT;
            r_cnt   <= 12'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 12'd1;
        if (sec_tick) begin
            unique case (r_phase)
                PH_NIGHT: begin
                    if (l_sense > LIGHT_HI) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_PERSIST) begin
                            w_phase_nxt = PH_DAWN;
                            w_cnt_nxt   = 12'd0;
                        end
                    end else begin
                        w_cnt_nxt = 12'd0;
                    end
                end
                PH_DAWN: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_DWELL) begin
                        w_phase_nxt = PH_DAY;
                        w_cnt_nxt   = 12'd0;
                    end
                end
                PH_DAY: begin
                    if (l_sense < LIGHT_LO) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_PERSIST) begin
                            w_phase_nxt = PH_DUSK;
                            w_cnt_nxt   = 12'd0;
                        end
                    end else begin
                        w_cnt_nxt = 12'd0;
                    end
                end
                PH_DUSK: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_DWELL) begin
                        w_phase_nxt = PH_NIGHT;
                        w_cnt_nxt   = 12'd0;
                    end
                end
            endcase
        end
    end

    assign l_thresh = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_conditioner
// Description : Self-checking bench for sensor_conditioner with a behavioural
//               reference model. Honours MEDIAN3_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_conditioner;

    localparam int c_HI      = 120;
    localparam int c_LO      = 60;
    localparam int c_PERSIST = 600;
    localparam int c_DWELL   = 1800;
`ifdef MEDIAN3_EN
    localparam int c_EXP_MED = 50;
    localparam int c_EXP_AVG = 12;
    localparam int c_EXP_ILM = 177;
`else
    localparam int c_EXP_MED = 75;
    localparam int c_EXP_AVG = 13;
    localparam int c_EXP_ILM = 200;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0;
    logic       adc_valid = 1'b0;
    logic       adc_chan = 1'b0;
    logic [7:0] adc_data = 8'd0;
    logic       adc_ready;
    logic [7:0] m_sense;
    logic [7:0] l_sense;
    logic [1:0] l_thresh;
    logic       m_valid;
    logic       l_valid;

    always #5 clk = ~clk;

    sensor_conditioner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_tick  (sec_tick),
        .adc_valid (adc_valid),
        .adc_chan  (adc_chan),
        .adc_data  (adc_data),
        .adc_ready (adc_ready),
        .m_sense   (m_sense),
        .l_sense   (l_sense),
        .l_thresh  (l_thresh),
        .m_valid   (m_valid),
        .l_valid   (l_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model state: expected outputs, open windows, filter history.
    int exp_m, exp_l, exp_ph, run;
    bit exp_mv, exp_lv;
    int win_sum [2];
    int win_n   [2];
    int hist    [2][2];
    bit primed  [2];

    function automatic void model_reset();
        exp_m = 255; exp_l = 0; exp_ph = 0; run = 0;
        exp_mv = 0; exp_lv = 0;
        for (int c = 0; c < 2; c++) begin
            win_sum[c] = 0; win_n[c] = 0; primed[c] = 0;
            hist[c][0] = 0; hist[c][1] = 0;
        end
    endfunction

    function automatic int filt(input int ch, input int x);
`ifdef MEDIAN3_EN
        int a, b, mx, mn;
        if (!primed[ch]) begin
            primed[ch] = 1; hist[ch][0] = x; hist[ch][1] = x;
            return x;
        end
        a = hist[ch][0]; b = hist[ch][1];
        mx = (x > a) ? x : a; mx = (mx > b) ? mx : b;
        mn = (x < a) ? x : a; mn = (mn < b) ? mn : b;
        hist[ch][1] = a; hist[ch][0] = x;
        return x + a + b - mx - mn;
`else
        return x + ch - ch;
`endif
    endfunction

    function automatic void phase_tick(input int lvl);
        case (exp_ph)
            0: begin run = (lvl > c_HI) ? run + 1 : 0; if (run == c_PERSIST) begin exp_ph = 1; run = 0; end end
            1: begin run++; if (run == c_DWELL) begin exp_ph = 2; run = 0; end end
            2: begin run = (lvl < c_LO) ? run + 1 : 0; if (run == c_PERSIST) begin exp_ph = 3; run = 0; end end
            default: begin run++; if (run == c_DWELL) begin exp_ph = 0; run = 0; end end
        endcase
    endfunction

    function automatic void model_edge(input bit acc, input int ch, input int d, input bit t);
        int f;
        exp_mv = 0; exp_lv = 0;
        if (t) phase_tick(exp_l);
        if (acc) begin
            f = filt(ch, d);
            win_sum[ch] += f;
            win_n[ch]++;
            if (win_n[ch] == 8) begin
                if (ch == 0) begin exp_m = win_sum[ch] / 8; exp_mv = 1; end
                else         begin exp_l = win_sum[ch] / 8; exp_lv = 1; end
                win_sum[ch] = 0; win_n[ch] = 0;
            end
        end
    endfunction

    task automatic cycle(input bit v, input bit ch, input logic [7:0] d, input bit t, output bit acc);
        bit rdy;
        adc_valid = v; adc_chan = ch; adc_data = d; sec_tick = t;
        rdy = rst_n && !(exp_mv || exp_lv);
        #1 chk("adc_ready", adc_ready, rdy);
        acc = v && rdy;
        @(posedge clk);
        if (rst_n) model_edge(acc, int'(ch), int'(d), t);
        #1;
        chk("m_sense", m_sense, exp_m);
        chk("l_sense", l_sense, exp_l);
        chk("l_thresh", l_thresh, exp_ph);
        chk("m_valid", m_valid, exp_mv);
        chk("l_valid", l_valid, exp_lv);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(0, 0, 8'd0, 0, acc);
    endtask

    task automatic send(input bit ch, input logic [7:0] d);
        bit acc;
        int tries;
        tries = 0;
        do begin
            cycle(1, ch, d, 0, acc);
            tries++;
        end while (!acc && tries < 4);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic ticks(input int n);
        bit acc;
        repeat (n) begin
            cycle(0, 0, 8'd0, 1, acc);
            cycle(0, 0, 8'd0, 0, acc);
        end
    endtask

    // Two windows so the second is free of any median history carry-over.
    task automatic light_win(input logic [7:0] v);
        repeat (16) send(1, v);
        idle(1);
    endtask

    initial begin
        bit acc;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk("ready_in_reset", adc_ready, 0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_m_sense", m_sense, 8'hFF);
        chk("rst_l_sense", l_sense, 0);
        chk("rst_l_thresh", l_thresh, 0);
        chk("rst_ready", adc_ready, 1);

        for (int i = 0; i < 8; i++) send(0, (i == 2) ? 8'd250 : 8'd50);
        chk("median_spike", m_sense, c_EXP_MED);
        idle(1);

        repeat (300) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), acc);

        repeat (3) send(0, 8'($urandom_range(0, 255)));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_m", m_sense, 8'hFF);
        chk("async_rst_l", l_sense, 0);
        chk("async_rst_ph", l_thresh, 0);
        chk("async_rst_ready", adc_ready, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) send(0, 8'(10 + i));
        chk("avg_10_17", m_sense, c_EXP_AVG);
        chk("ready_commit", adc_ready, 0);
        idle(1);
        chk("ready_after_commit", adc_ready, 1);

        for (int i = 0; i < 16; i++) send(i[0], i[0] ? 8'd100 : 8'd200);
        idle(2);
        chk("ilv_m_sense", m_sense, c_EXP_ILM);
        chk("ilv_l_sense", l_sense, 100);

        light_win(8'd120);
        ticks(700);
        chk("hi_boundary_night", l_thresh, 0);
        light_win(8'd121);
        ticks(300);
        light_win(8'd90);
        ticks(1);
        light_win(8'd121);
        ticks(599);
        chk("restart_pre_dawn", l_thresh, 0);
        ticks(1);
        chk("dawn_on_600th", l_thresh, 1);

        light_win(8'd60);
        ticks(1799);
        chk("dawn_hold", l_thresh, 1);
        ticks(1);
        chk("day", l_thresh, 2);
        ticks(650);
        chk("lo_boundary_day", l_thresh, 2);
        light_win(8'd59);
        ticks(599);
        chk("pre_dusk", l_thresh, 2);
        ticks(1);
        chk("dusk", l_thresh, 3);
        ticks(1799);
        chk("dusk_hold", l_thresh, 3);
        ticks(1);
        chk("night_again", l_thresh, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Upstream stage of the irrigation controller FSM. Sits between the ADC and the FSM.
- Accepts interleaved moisture/light samples from the ADC over a valid/ready handshake and box-car averages each channel.
- Drives the FSM inputs: m_sense, l_sense, and a 2-bit daylight phase (l_thresh) derived with hysteresis and a seconds-based persistence timer.
- l_thresh == 2'b01 (DAWN) is the FSM's dawn trigger.

Parameters:
- AVG_LOG2, 3, log2 of samples averaged per channel window (8 samples).
- LIGHT_HI, 8'd120, l_sense must be strictly above this to count as bright.
- LIGHT_LO, 8'd60, l_sense must be strictly below this to count as dark.
- PERSIST_SEC, 600, consecutive seconds a bright or dark condition must hold before a phase change (10 min).
- DAWN_SEC, 1800, seconds spent in DAWN and in DUSK before advancing.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse per second, synchronous to clk
- adc_valid  in  1  ADC sample valid
- adc_chan  in  1  0 = moisture, 1 = light
- adc_data  in  8  ADC sample
- adc_ready  out  1  block can accept a sample
- m_sense  out  8  averaged moisture, to FSM
- l_sense  out  8  averaged light, to FSM
- l_thresh  out  2  phase: 00 NIGHT, 01 DAWN, 10 DAY, 11 DUSK
- m_valid  out  1  one-cycle pulse when m_sense updates
- l_valid  out  1  one-cycle pulse when l_sense updates

Behaviour:
- Reset values:
  - m_sense = 8'hFF (reads as wet, so no watering at power-up).
  - l_sense = 0, l_thresh = NIGHT.
  - m_valid = 0, l_valid = 0, adc_ready = 0 while rst_n is low.
  - All accumulators, sample counters and the phase counter = 0.
- Handshake:
  - A sample transfers when adc_valid && adc_ready.
  - adc_ready is 1 except in the single commit cycle after any channel window completes.
  - The ADC must hold its data while ready is low.
- Averaging, per channel:
  - Accumulator is 8+AVG_LOG2 bits wide; the sample counter is AVG_LOG2 bits.
  - On the 2^AVG_LOG2-th accepted sample, the next cycle (commit):
    - output = accumulator >> AVG_LOG2 (truncated, never rounds up);
    - that channel's valid pulses for 1 cycle;
    - accumulator and counter clear.
  - Latency from the last sample accepted to the output update is 1 cycle.
  - If both channels complete windows on consecutive transfers, each commits in its own cycle; no sample is lost.
- Light phase FSM:
  - Uses registered l_sense only; a sec_tick in the same cycle as an l_sense update sees the old value.
  - Shared 12-bit phase counter; it saturates and never wraps.
  - NIGHT:
    - On each sec_tick with l_sense > LIGHT_HI, cnt += 1; otherwise cnt = 0.
    - On the tick where cnt reaches PERSIST_SEC: go to DAWN, cnt = 0.
  - DAWN: cnt += 1 on every tick; when cnt reaches DAWN_SEC, go to DAY with cnt = 0. Light level is ignored.
  - DAY: mirror of NIGHT using l_sense < LIGHT_LO; on reaching PERSIST_SEC, go to DUSK.
  - DUSK: mirror of DAWN; on reaching DAWN_SEC, go to NIGHT.
  - Hysteresis boundaries:
    - l_sense == LIGHT_HI is not bright; l_sense == LIGHT_LO is not dark.
    - A value between LIGHT_LO and LIGHT_HI clears the persistence count in both NIGHT and DAY.
- Reset mid-window or mid-persistence discards partial sums and counts immediately; the asynchronous assert needs no clock.
- sec_tick and a sample transfer in the same cycle are both processed.

Optional Feature:
MEDIAN3_EN
- Defined: each channel passes through a 3-tap median prefilter (current sample plus two previous accepted samples of that channel) before accumulation.
  - The first sample after reset preloads both history taps, so there is no startup bias.
  - Latency is unchanged; the median is combinational on the accepted sample.
- Undefined: raw samples are accumulated and the history registers are not built.

Decomposition:
- Shared package sensor_pkg holds:
  - the phase encoding constants PH_NIGHT/PH_DAWN/PH_DAY/PH_DUSK (the FSM consumes PH_DAWN);
  - the channel IDs CH_MOIST/CH_LIGHT.
- One sub-module, chan_avg, instantiated twice. It contains the accumulator, sample counter, optional median, commit and valid logic.
- The phase FSM and the handshake stay in the top level.

Test Plan:
- Reset: release rst_n with no samples → m_sense = FF, l_sense = 0, l_thresh = 00, adc_ready = 1 on the first cycle after release.
- Averaging: 8 moisture samples 10,11,…,17 with valid held high → after the commit cycle m_sense = 13, m_valid pulses once, adc_ready low exactly 1 cycle.
- Interleave: alternate moisture 200 / light 100 for 16 transfers → m_sense = 200, l_sense = 100, two distinct valid pulses, no dropped transfer.
- Dawn persistence:
  - l_sense = 121, then 600 ticks → l_thresh = 01 on the 600th tick.
  - With l_sense = 120, no transition after 700 ticks.
  - A mid-run l_sense = 90 restarts the count.
- Full cycle: DAWN for 1800 ticks → DAY; l_sense = 59 for 600 ticks → DUSK; 1800 ticks → NIGHT.
- MEDIAN3_EN: moisture samples 50,50,250,50,… → the 250 spike is rejected and m_sense = 50. With the macro off, m_sense = 75.
